// File: rtl/frame_deframer.sv
// frame_deframer: receive-side byte-stream deframer.
// Hunts for FRAME_START, removes ESC_VAL/ESC_XOR byte stuffing, checks the
// de-stuffed byte count at FRAME_END and holds the finished frame until the
// consumer accepts it. Errors are reported as one-cycle registered pulses.
// Optional feature macro: DEFRAMER_STATS_EN (frame/error statistics counters).
module frame_deframer #(
  parameter int DATA_SIZE     = 64,
  parameter int PREAMBLE_SIZE = 7,
  parameter int CRC_SIZE      = 4,
  parameter int FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE,
  parameter int FRAME_BITS    = FRAME_BYTES * 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_valid,
  output logic [0:FRAME_BITS-1] o_frame_out,
  output logic                  o_frame_valid,
  input  logic                  i_frame_ready,
  output logic                  o_err_valid,
  output logic [7:0]            o_err_code,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_err_cnt
);

  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END   = 8'h07;
  localparam logic [7:0] ESC_VAL     = 8'h14;
  localparam logic [7:0] ESC_XOR     = 8'h20;

  localparam logic [7:0] ERR_LENGTH  = 8'h01;
  localparam logic [7:0] ERR_OVERFL  = 8'h02;
  localparam logic [7:0] ERR_BADESC  = 8'h03;
  localparam logic [7:0] ERR_DROP    = 8'h04;
  localparam logic [7:0] ERR_RESYNC  = 8'h05;

  localparam logic [6:0] FULL_IDX = 7'(FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_RECV = 2'd1,
    ST_ESC  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  logic [6:0]            r_idx;
  logic [0:FRAME_BITS-1] r_frame;
  logic                  r_frame_valid;
  logic                  r_err_valid;
  logic [7:0]            r_err_code;

  state_t     w_state_nxt;
  logic [6:0] w_idx_nxt;
  logic       w_wr_en;
  logic [7:0] w_wr_data;
  logic       w_err;
  logic [7:0] w_err_code;
  logic       w_accept;
  logic       w_full;

  assign w_full = (r_idx == FULL_IDX);

  // Next-state, byte-store and error decode for every received byte.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_wr_data   = i_rx_byte;
    w_err       = 1'b0;
    w_err_code  = 8'h00;
    w_accept    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (i_rx_valid && (i_rx_byte == FRAME_START)) begin
          w_state_nxt = ST_RECV;
          w_idx_nxt   = 7'd0;
        end else begin
          w_state_nxt = ST_HUNT;
        end
      end
      ST_RECV, ST_ESC: begin
        if (!i_rx_valid) begin
          w_state_nxt = r_state;
        end else if (i_rx_byte == FRAME_START) begin
          w_err       = 1'b1;
          w_err_code  = ERR_RESYNC;
          w_idx_nxt   = 7'd0;
          w_state_nxt = ST_RECV;
        end else if (i_rx_byte == FRAME_END) begin
          if (r_state == ST_ESC) begin
            w_err       = 1'b1;
            w_err_code  = ERR_BADESC;
            w_state_nxt = ST_HUNT;
          end else if (w_full) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_err       = 1'b1;
            w_err_code  = ERR_LENGTH;
            w_state_nxt = ST_HUNT;
          end
        end else if ((r_state == ST_RECV) && (i_rx_byte == ESC_VAL)) begin
          w_state_nxt = ST_ESC;
        end else if (w_full) begin
          w_err       = 1'b1;
          w_err_code  = ERR_OVERFL;
          w_state_nxt = ST_HUNT;
        end else begin
          w_wr_en     = 1'b1;
          w_wr_data   = (r_state == ST_ESC) ? (i_rx_byte ^ ESC_XOR) : i_rx_byte;
          w_idx_nxt   = r_idx + 7'd1;
          w_state_nxt = ST_RECV;
        end
      end
      ST_HOLD: begin
        if (i_frame_ready) begin
          // Acceptance cycle: a coincident byte is judged as if already hunting.
          w_accept = 1'b1;
          if (i_rx_valid && (i_rx_byte == FRAME_START)) begin
            w_state_nxt = ST_RECV;
            w_idx_nxt   = 7'd0;
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end else if (i_rx_valid) begin
          w_err      = 1'b1;
          w_err_code = ERR_DROP;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_idx_nxt   = 7'd0;
      end
    endcase
  end

  // State, byte index and frame buffer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_HUNT;
      r_idx         <= 7'd0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_frame_valid <= (w_state_nxt == ST_HOLD);
      if (w_wr_en) begin
        r_frame[{r_idx, 3'b000} +: 8] <= w_wr_data;
      end
    end
  end

  // Registered error pulse; the code is sticky between pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_valid <= 1'b0;
      r_err_code  <= 8'h00;
    end else begin
      r_err_valid <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
      end
    end
  end

`ifdef DEFRAMER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  // Saturating delivered-frame and error counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'h0000;
      r_err_cnt   <= 16'h0000;
    end else begin
      if (w_accept && (r_frame_cnt != 16'hFFFF)) begin
        r_frame_cnt <= r_frame_cnt + 16'h0001;
      end
      if (r_err_valid && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'h0001;
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
`else
  assign o_frame_cnt = 16'h0000;
  assign o_err_cnt   = 16'h0000;
`endif

  assign o_frame_out   = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_err_valid   = r_err_valid;
  assign o_err_code    = r_err_code;

endmodule
